// File: rtl/ff_fold_accumulator_pkg.sv
// Shared Q-format constants, fan-in/fold geometry helpers and saturating arithmetic
// for the feedforward pre-activation engine.
package ff_fold_accumulator_pkg;

    localparam int WIDTH_DEF     = 16;
    localparam int INT_BITS_DEF  = 5;
    localparam int FRAC_BITS_DEF = 10;

    function automatic int calc_npc(input int z, input int fi);
        return (z > fi) ? z / fi : 1;
    endfunction

    function automatic int calc_beats(input int z, input int fi);
        return (fi > z) ? fi / z : 1;
    endfunction

    // lanes feeding one neuron within a single beat
    function automatic int calc_lpn(input int z, input int fi);
        return (fi < z) ? fi : z;
    endfunction

    function automatic int calc_acc_w(input int w, input int fi);
        return w + $clog2((fi > 2) ? fi : 2) + 1;
    endfunction

    function automatic logic is_clamped(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (v > hi) || (v < lo);
    endfunction

    function automatic logic signed [63:0] clamp_to_width(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // arithmetic shift floors toward -inf, matching the fixed-point rounding intent
    function automatic logic signed [63:0] sat_mul(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w, input int frac);
        logic signed [63:0] p;
        p = (a * b) >>> frac;
        return clamp_to_width(p, w);
    endfunction

endpackage

// File: rtl/ff_fold_accumulator_if.sv
// Beat-in / pre-activation-out stream bundle; slave side faces the engine.
interface ff_fold_accumulator_if #(
    parameter int WIDTH = ff_fold_accumulator_pkg::WIDTH_DEF,
    parameter int Z     = 8,
    parameter int NPC   = 2
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH*Z-1:0]     a_package;
    logic [WIDTH*Z-1:0]     w_package;
    logic [WIDTH*NPC-1:0]   b_package;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH*NPC-1:0]   s_package;
    logic [NPC-1:0]         sat_flags;

    modport slave (
        input  in_valid, a_package, w_package, b_package, out_ready,
        output in_ready, out_valid, s_package, sat_flags
    );

    modport master (
        output in_valid, a_package, w_package, b_package, out_ready,
        input  in_ready, out_valid, s_package, sat_flags
    );
endinterface

// File: rtl/ff_fold_accumulator_tree_adder.sv
// Combinational n-to-1 signed reducer built as a recursive balanced tree.
module ff_tree_adder #(
    parameter int n    = 2,
    parameter int in_w = 16
) (
    input  logic [n-1:0][in_w-1:0]     i_in,
    output logic [in_w+$clog2(n)-1:0]  o_sum
);
    localparam int OW = in_w + $clog2(n);

    generate
        if (n == 1) begin : g_leaf
            assign o_sum = i_in[0];
        end else begin : g_split
            localparam int H  = n / 2;
            localparam int HW = in_w + $clog2(H);
            logic [HW-1:0] w_lo, w_hi;

            ff_tree_adder #(.n(H), .in_w(in_w)) u_lo (.i_in(i_in[H-1:0]), .o_sum(w_lo));
            ff_tree_adder #(.n(H), .in_w(in_w)) u_hi (.i_in(i_in[n-1:H]), .o_sum(w_hi));

            assign o_sum = OW'(signed'(w_lo)) + OW'(signed'(w_hi));
        end
    endgenerate
endmodule

// File: rtl/ff_fold_accumulator.sv
// Two-stage feedforward engine: saturating lane multiply, then per-neuron tree sum
// with bias and multi-beat folding, clamped into a stallable output register.
module ff_fold_accumulator import ff_fold_accumulator_pkg::*; #(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int INT_BITS  = INT_BITS_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int Z         = 8,
    parameter int FI        = 4,
    localparam int NPC      = calc_npc(Z, FI),
    localparam int BEATS    = calc_beats(Z, FI),
    localparam int ACC_W    = calc_acc_w(WIDTH, FI),
    localparam int LPN      = calc_lpn(Z, FI),
    localparam int TREE_W   = WIDTH + $clog2(LPN),
    localparam int BW       = $clog2((BEATS > 1) ? BEATS : 2)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    ff_fold_accumulator_if.slave bus
);
    // saturation bound comes from the Q format, not just the storage width
    localparam int QW = 1 + INT_BITS + FRAC_BITS;

    logic [Z-1:0][WIDTH-1:0]    w_a, w_w, w_prod;
    logic [NPC-1:0][WIDTH-1:0]  w_b;
    logic [NPC-1:0][TREE_W-1:0] w_sum;
    logic [NPC-1:0][ACC_W-1:0]  w_acc_nxt;
    logic [NPC-1:0][WIDTH-1:0]  w_s;
    logic [NPC-1:0]             w_sat;
    logic                       w_adv, w_accept, w_acc_en, w_last;

    logic [1:0]                 r_vld_pipe;
    logic [Z-1:0][WIDTH-1:0]    r_s1_prod;
    logic [NPC-1:0][WIDTH-1:0]  r_s1_b;
    logic [BW-1:0]              r_s1_beat;
    logic [BW-1:0]              r_beat;
    logic [NPC-1:0][ACC_W-1:0]  r_acc;
    logic [NPC-1:0][WIDTH-1:0]  r_s;
    logic [NPC-1:0]             r_sat;

    assign w_a = bus.a_package;
    assign w_w = bus.w_package;
    assign w_b = bus.b_package;

    assign w_adv        = !r_vld_pipe[1] || bus.out_ready;
    assign bus.in_ready = reset_n && w_adv && !flush;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_acc_en     = w_adv && r_vld_pipe[0] && !flush;
    assign w_last       = (r_s1_beat == BW'(BEATS - 1));

    genvar k, j;
    generate
        for (k = 0; k < Z; k++) begin : g_lane
            assign w_prod[k] = WIDTH'(sat_mul(64'(signed'(w_a[k])), 64'(signed'(w_w[k])),
                                              QW, FRAC_BITS));
        end

        for (j = 0; j < NPC; j++) begin : g_neuron
            ff_tree_adder #(.n(LPN), .in_w(WIDTH)) u_tree (
                .i_in  (r_s1_prod[j*LPN +: LPN]),
                .o_sum (w_sum[j])
            );
            // beat 0 seeds the running sum with the bias instead of the stale total
            assign w_acc_nxt[j] = ((r_s1_beat == '0) ? ACC_W'(signed'(r_s1_b[j])) : r_acc[j])
                                  + ACC_W'(signed'(w_sum[j]));
            assign w_s[j]   = WIDTH'(clamp_to_width(64'(signed'(w_acc_nxt[j])), QW));
            assign w_sat[j] = is_clamped(64'(signed'(w_acc_nxt[j])), QW);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
            r_s1_prod  <= '0;
            r_s1_b     <= '0;
            r_s1_beat  <= '0;
            r_beat     <= '0;
            r_acc      <= '0;
            r_s        <= '0;
            r_sat      <= '0;
        end else begin
            if (flush) begin
                r_beat        <= '0;
                r_acc         <= '0;
                r_vld_pipe[0] <= 1'b0;
            end else if (w_adv) begin
                r_vld_pipe[0] <= w_accept;
                if (w_accept) begin
                    r_s1_prod <= w_prod;
                    r_s1_b    <= w_b;
                    r_s1_beat <= r_beat;
                    r_beat    <= (r_beat == BW'(BEATS - 1)) ? '0 : r_beat + BW'(1);
                end
                if (w_acc_en) r_acc <= w_acc_nxt;
            end

            // a completed output survives flush; it leaves only when consumed
            if (w_adv) begin
                if (w_acc_en && w_last) begin
                    r_vld_pipe[1] <= 1'b1;
                    r_s           <= w_s;
                    r_sat         <= w_sat;
                end else begin
                    r_vld_pipe[1] <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid = r_vld_pipe[1];
    assign bus.s_package = r_s;
    assign bus.sat_flags = r_sat;

endmodule

// File: tb/tb_ff_fold_accumulator.sv
// Directed bench: a packed instance (z=8, fi=4) and a folded instance (z=4, fi=16).
module tb_ff_fold_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, flush_a, flush_b;
    int   n_chk  = 0;
    int   n_fail = 0;

    ff_fold_accumulator_if #(.WIDTH(16), .Z(8), .NPC(2)) ifa ();
    ff_fold_accumulator_if #(.WIDTH(16), .Z(4), .NPC(1)) ifb ();

    ff_fold_accumulator #(.Z(8), .FI(4)) u_a (
        .clk(clk), .reset_n(reset_n), .flush(flush_a), .bus(ifa.slave)
    );
    ff_fold_accumulator #(.Z(4), .FI(16)) u_b (
        .clk(clk), .reset_n(reset_n), .flush(flush_b), .bus(ifb.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_b(input logic [15:0] a, input logic [15:0] w,
                          input logic [15:0] b0, input int nb);
        for (int i = 0; i < nb; i++) begin
            ifb.in_valid  = 1'b1;
            ifb.a_package = {4{a}};
            ifb.w_package = {4{w}};
            ifb.b_package = (i == 0) ? b0 : 16'h7FFF;
            step();
        end
        ifb.in_valid = 1'b0;
    endtask

    task automatic wait_b(output bit got);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (ifb.out_valid) got = 1'b1;
            else step();
        end
    endtask

    task automatic test_reset();
        #12;
        n_chk++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_valid: got %b want 0", ifa.out_valid); end
        n_chk++; if (ifa.s_package !== 32'h0) begin n_fail++; $display("FAIL rst_a_s: got %h want 0", ifa.s_package); end
        n_chk++; if (ifa.sat_flags !== 2'b00) begin n_fail++; $display("FAIL rst_a_sat: got %b want 00", ifa.sat_flags); end
        n_chk++; if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_a_ready: got %b want 0", ifa.in_ready); end
        n_chk++; if (ifb.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_b_ready: got %b want 0", ifb.in_ready); end
        n_chk++; if (ifb.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid: got %b want 0", ifb.out_valid); end
        step();
        reset_n = 1'b1;
        #1;
        n_chk++; if (ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", ifa.in_ready); end
    endtask

    task automatic test_basic();
        ifa.in_valid  = 1'b1;
        ifa.a_package = {8{16'h0400}};
        ifa.w_package = {8{16'h0200}};
        ifa.b_package = {2{16'h0100}};
        step();
        ifa.in_valid = 1'b0;
        n_chk++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat1: got %b want 0", ifa.out_valid); end
        step();
        n_chk++; if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_lat2: got %b want 1", ifa.out_valid); end
        n_chk++; if (ifa.s_package !== 32'h0900_0900) begin n_fail++; $display("FAIL basic_s: got %h want 09000900", ifa.s_package); end
        n_chk++; if (ifa.sat_flags !== 2'b00) begin n_fail++; $display("FAIL basic_sat: got %b want 00", ifa.sat_flags); end
        step();
        n_chk++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", ifa.out_valid); end
    endtask

    task automatic test_mul_sat_floor();
        logic [7:0][15:0] av, wv;
        av = '0; wv = '0;
        av[0] = 16'h2000; wv[0] = 16'h2000;   // 8*8  -> +64 saturates to 0x7FFF
        av[1] = 16'hE000; wv[1] = 16'h2000;   // -8*8 -> -64 saturates to 0x8000
        av[4] = 16'h0001; wv[4] = 16'hFFFF;   // -2^-20 floors to -1 lsb
        av[5] = 16'h0001; wv[5] = 16'h0001;   // +2^-20 floors to 0
        ifa.in_valid  = 1'b1;
        ifa.a_package = av;
        ifa.w_package = wv;
        ifa.b_package = 32'h0;
        step();
        ifa.in_valid = 1'b0;
        step();
        n_chk++; if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL mul_valid: got %b want 1", ifa.out_valid); end
        n_chk++; if (ifa.s_package !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mul_s: got %h want ffffffff", ifa.s_package); end
        n_chk++; if (ifa.sat_flags !== 2'b00) begin n_fail++; $display("FAIL mul_sat: got %b want 00", ifa.sat_flags); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_s [0:5];
        logic [31:0] held;
        bit          holding, acc_pend;
        int          g, idx;
        exp_s[0] = 32'h0400_0400; exp_s[1] = 32'h0900_0800; exp_s[2] = 32'h0E00_0C00;
        exp_s[3] = 32'h1300_1000; exp_s[4] = 32'h1800_1400; exp_s[5] = 32'h1D00_1800;
        g = 0; idx = 0; holding = 1'b0; acc_pend = 1'b0; held = '0;
        for (int cyc = 0; cyc < 60 && idx < 6; cyc++) begin
            if (acc_pend) g++;
            if (g < 6) begin
                ifa.in_valid  = 1'b1;
                ifa.a_package = {8{16'h0400}};
                ifa.w_package = {8{16'((g + 1) * 256)}};
                ifa.b_package = {16'(g * 256), 16'h0000};
            end else begin
                ifa.in_valid = 1'b0;
            end
            ifa.out_ready = !(cyc >= 3 && cyc < 8);
            #1;
            acc_pend = ifa.in_valid && ifa.in_ready;
            if (!ifa.out_ready && ifa.out_valid) begin
                n_chk++; if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc%0d: got %b want 0", cyc, ifa.in_ready); end
                if (holding) begin
                    n_chk++; if (ifa.s_package !== held) begin n_fail++; $display("FAIL bp_hold cyc%0d: got %h want %h", cyc, ifa.s_package, held); end
                end
                held = ifa.s_package; holding = 1'b1;
            end
            if (ifa.out_valid && ifa.out_ready) begin
                n_chk++; if (ifa.s_package !== exp_s[idx]) begin n_fail++; $display("FAIL b2b_s[%0d]: got %h want %h", idx, ifa.s_package, exp_s[idx]); end
                idx++;
            end
            step();
        end
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        n_chk++; if (idx != 6) begin n_fail++; $display("FAIL b2b_count: got %0d want 6", idx); end
        n_chk++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_extra: got %b want 0", ifa.out_valid); end
    endtask

    task automatic test_fold();
        for (int i = 0; i < 4; i++) begin
            ifb.in_valid  = 1'b1;
            ifb.a_package = {4{16'h0400}};
            ifb.w_package = {4{16'h0400}};
            ifb.b_package = (i == 0) ? 16'h0000 : 16'h7FFF;
            step();
            n_chk++; if (ifb.out_valid !== 1'b0) begin n_fail++; $display("FAIL fold_early beat%0d: got %b want 0", i, ifb.out_valid); end
        end
        ifb.in_valid = 1'b0;
        step();
        n_chk++; if (ifb.out_valid !== 1'b1) begin n_fail++; $display("FAIL fold_valid: got %b want 1", ifb.out_valid); end
        n_chk++; if (ifb.s_package !== 16'h4000) begin n_fail++; $display("FAIL fold_s: got %h want 4000", ifb.s_package); end
        n_chk++; if (ifb.sat_flags !== 1'b0) begin n_fail++; $display("FAIL fold_sat: got %b want 0", ifb.sat_flags); end
        step();
        n_chk++; if (ifb.out_valid !== 1'b0) begin n_fail++; $display("FAIL fold_once: got %b want 0", ifb.out_valid); end
    endtask

    task automatic test_saturation();
        bit got;
        send_b(16'h1000, 16'h1000, 16'h0000, 4);
        wait_b(got);
        n_chk++; if (!got) begin n_fail++; $display("FAIL satp_timeout: got 0 want 1"); end
        n_chk++; if (ifb.s_package !== 16'h7FFF) begin n_fail++; $display("FAIL satp_s: got %h want 7fff", ifb.s_package); end
        n_chk++; if (ifb.sat_flags !== 1'b1) begin n_fail++; $display("FAIL satp_flag: got %b want 1", ifb.sat_flags); end
        step();
        send_b(16'hFC00, 16'h0400, 16'h8000, 4);
        wait_b(got);
        n_chk++; if (!got) begin n_fail++; $display("FAIL satn_timeout: got 0 want 1"); end
        n_chk++; if (ifb.s_package !== 16'h8000) begin n_fail++; $display("FAIL satn_s: got %h want 8000", ifb.s_package); end
        n_chk++; if (ifb.sat_flags !== 1'b1) begin n_fail++; $display("FAIL satn_flag: got %b want 1", ifb.sat_flags); end
        step();
    endtask

    task automatic test_flush();
        bit got;
        ifb.out_ready = 1'b0;
        send_b(16'h0400, 16'h0400, 16'h0000, 4);
        wait_b(got);
        n_chk++; if (!got) begin n_fail++; $display("FAIL flush_hold_timeout: got 0 want 1"); end
        flush_b = 1'b1;
        step();
        flush_b = 1'b0;
        n_chk++; if (ifb.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_keep_valid: got %b want 1", ifb.out_valid); end
        n_chk++; if (ifb.s_package !== 16'h4000) begin n_fail++; $display("FAIL flush_keep_s: got %h want 4000", ifb.s_package); end
        ifb.out_ready = 1'b1;
        step();
        send_b(16'h1000, 16'h1000, 16'h0000, 2);
        flush_b       = 1'b1;
        ifb.in_valid  = 1'b1;
        ifb.a_package = {4{16'h1000}};
        ifb.w_package = {4{16'h1000}};
        #1;
        n_chk++; if (ifb.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", ifb.in_ready); end
        step();
        flush_b      = 1'b0;
        ifb.in_valid = 1'b0;
        step();
        step();
        n_chk++; if (ifb.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_aborted_out: got %b want 0", ifb.out_valid); end
        send_b(16'h0400, 16'h0400, 16'h0000, 4);
        wait_b(got);
        n_chk++; if (!got) begin n_fail++; $display("FAIL flush_clean_timeout: got 0 want 1"); end
        n_chk++; if (ifb.s_package !== 16'h4000) begin n_fail++; $display("FAIL flush_clean_s: got %h want 4000", ifb.s_package); end
        n_chk++; if (ifb.sat_flags !== 1'b0) begin n_fail++; $display("FAIL flush_clean_sat: got %b want 0", ifb.sat_flags); end
        step();
    endtask

    task automatic test_reset_mid();
        bit got;
        ifb.out_ready = 1'b0;
        send_b(16'h0400, 16'h0400, 16'h0000, 5);
        n_chk++; if (ifb.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b want 1", ifb.out_valid); end
        #3;
        reset_n = 1'b0;
        #1;
        n_chk++; if (ifb.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", ifb.out_valid); end
        n_chk++; if (ifb.s_package !== 16'h0000) begin n_fail++; $display("FAIL rmid_s: got %h want 0000", ifb.s_package); end
        n_chk++; if (ifb.sat_flags !== 1'b0) begin n_fail++; $display("FAIL rmid_sat: got %b want 0", ifb.sat_flags); end
        n_chk++; if (ifb.in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready: got %b want 0", ifb.in_ready); end
        #2;
        reset_n       = 1'b1;
        ifb.out_ready = 1'b1;
        step();
        send_b(16'h0400, 16'h0400, 16'h0100, 4);
        wait_b(got);
        n_chk++; if (!got) begin n_fail++; $display("FAIL rmid_timeout: got 0 want 1"); end
        n_chk++; if (ifb.s_package !== 16'h4100) begin n_fail++; $display("FAIL rmid_after_s: got %h want 4100", ifb.s_package); end
        step();
    endtask

    initial begin
        reset_n = 1'b1;
        flush_a = 1'b0;
        flush_b = 1'b0;
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
        ifa.a_package = '0;  ifa.w_package = '0; ifa.b_package = '0;
        ifb.in_valid = 1'b0; ifb.out_ready = 1'b1;
        ifb.a_package = '0;  ifb.w_package = '0; ifb.b_package = '0;
        #2 reset_n = 1'b0;
        test_reset();
        test_basic();
        test_mul_sat_floor();
        test_back_to_back();
        test_fold();
        test_saturation();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
